mmio_sram_responder: RTL and testbench

- Memory-side responder for the CPU's data SRAM-style port (en / 4-bit byte wen / addr / wdata / rdata), serving a small MMIO register window instead of block RAM.
- Provides scratch registers, LED output, synchronized switch input, a free-running timer with compare, and a level timer interrupt intended for one ext_int bit.
- The parent decodes the MMIO window and drives en only for accesses inside it.
- Read timing matches the data RAM exactly, so the datapath cannot tell the two responders apart.

---
 rtl/mmio_sram_responder_pkg.sv | 32 +++
 rtl/mmio_sram_responder_if.sv | 21 ++
 rtl/mmio_sram_responder_timer.sv | 46 ++++
 rtl/mmio_sram_responder.sv | 127 ++++++++++++
 tb/tb_mmio_sram_responder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_sram_responder_pkg.sv
// Shared constants for the MMIO SRAM-port responder.
// Register selects, IRQ bit positions, reset defaults and byte merge helper.
package mmio_sram_responder_pkg;

  localparam logic [2:0] REG_SCRATCH0 = 3'd0;
  localparam logic [2:0] REG_SCRATCH1 = 3'd1;
  localparam logic [2:0] REG_LED      = 3'd2;
  localparam logic [2:0] REG_SWITCH   = 3'd3;
  localparam logic [2:0] REG_TIMER    = 3'd4;
  localparam logic [2:0] REG_COMPARE  = 3'd5;
  localparam logic [2:0] REG_IRQ_STAT = 3'd6;
  localparam logic [2:0] REG_IRQ_EN   = 3'd7;

  localparam int IRQ_PEND_BIT = 0;
  localparam int IRQ_EN_BIT   = 0;

  localparam logic [31:0] CMP_RST_DEF   = 32'hFFFF_FFFF;
  localparam logic [31:0] MMIO_WIN_BASE = 32'h8000_0000;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_sram_responder_if.sv
// SRAM-style data port between the CPU datapath and a memory responder.
// Master drives the strobe/address/data, slave returns registered rdata.
interface mmio_sram_responder_if #(
  parameter int ADDR_W = 16
);
  logic              en;
  logic [3:0]        wen;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  modport master (
    output en, wen, addr, wdata,
    input  rdata
  );

  modport slave (
    input  en, wen, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/mmio_sram_responder_timer.sv
// Free-running TIMER with COMPARE and a sticky pending flag.
// A match on pre-edge values sets pending even when a clear lands the same edge.
module mmio_timer
  import mmio_sram_responder_pkg::*;
#(
  parameter logic [31:0] CMP_RST = CMP_RST_DEF
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  timer_be,
  input  logic [3:0]  cmp_be,
  input  logic        clr,
  input  logic [31:0] wdata,
  output logic [31:0] timer,
  output logic [31:0] compare,
  output logic        pending,
  output logic        pending_nxt
);

  logic [31:0] timer_nxt;
  logic [31:0] cmp_nxt;
  logic        match;

  always_comb begin
    timer_nxt = timer + 32'd1;
    if (|timer_be) begin
      timer_nxt = byte_merge(timer, wdata, timer_be);
    end
    cmp_nxt     = byte_merge(compare, wdata, cmp_be);
    match       = (timer == compare);
    pending_nxt = match | (pending & ~clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer   <= '0;
      compare <= CMP_RST;
      pending <= 1'b0;
    end else begin
      timer   <= timer_nxt;
      compare <= cmp_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/mmio_sram_responder.sv
// MMIO register window on the data SRAM port: scratch, LED, switches, timer.
// Read-first, one-cycle rdata so it is indistinguishable from the data RAM.
module mmio_sram_responder
  import mmio_sram_responder_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter int          SW_W    = 8,
  parameter int          LED_W   = 16,
  parameter logic [31:0] CMP_RST = CMP_RST_DEF
)(
  input  logic                  clk,
  input  logic                  resetn,
  mmio_sram_responder_if.slave  bus,
  input  logic [SW_W-1:0]       sw,
  output logic [LED_W-1:0]      led,
  output logic                  timer_irq
);

  logic        hit;
  logic        wr;
  logic [2:0]  sel;
  logic [3:0]  be_s0, be_s1, be_led, be_tmr;
  logic [3:0]  be_cmp, be_ist, be_ien;
  logic [31:0] scratch0, scratch1;
  logic [31:0] led_wide;
  logic [31:0] timer, compare;
  logic [31:0] rd_val, rdata_q;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic        irq_en, irq_en_nxt;
  logic        pending, pending_nxt;
  logic        clr;
  logic        unused_bits;

  assign hit = (bus.addr[ADDR_W-1:5] == '0);
  assign sel = bus.addr[4:2];
  assign wr  = bus.en & hit;

  always_comb begin
    be_s0  = '0;
    be_s1  = '0;
    be_led = '0;
    be_tmr = '0;
    be_cmp = '0;
    be_ist = '0;
    be_ien = '0;
    if (wr) begin
      case (sel)
        REG_SCRATCH0: be_s0  = bus.wen;
        REG_SCRATCH1: be_s1  = bus.wen;
        REG_LED:      be_led = bus.wen;
        REG_TIMER:    be_tmr = bus.wen;
        REG_COMPARE:  be_cmp = bus.wen;
        REG_IRQ_STAT: be_ist = bus.wen;
        REG_IRQ_EN:   be_ien = bus.wen;
        default:      ;
      endcase
    end
  end

  assign led_wide = byte_merge({{(32-LED_W){1'b0}}, led},
                               bus.wdata, be_led);
  assign clr = be_ist[0] & bus.wdata[IRQ_PEND_BIT];
  assign irq_en_nxt = be_ien[0] ? bus.wdata[IRQ_EN_BIT] : irq_en;

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (sel)
        REG_SCRATCH0: rd_val = scratch0;
        REG_SCRATCH1: rd_val = scratch1;
        REG_LED:      rd_val = {{(32-LED_W){1'b0}}, led};
        REG_SWITCH:   rd_val = {{(32-SW_W){1'b0}}, sw_s2};
        REG_TIMER:    rd_val = timer;
        REG_COMPARE:  rd_val = compare;
        REG_IRQ_STAT: rd_val = {31'b0, pending};
        REG_IRQ_EN:   rd_val = {31'b0, irq_en};
        default:      rd_val = '0;
      endcase
    end
  end

  mmio_timer #(
    .CMP_RST (CMP_RST)
  ) u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .timer_be    (be_tmr),
    .cmp_be      (be_cmp),
    .clr         (clr),
    .wdata       (bus.wdata),
    .timer       (timer),
    .compare     (compare),
    .pending     (pending),
    .pending_nxt (pending_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scratch0  <= '0;
      scratch1  <= '0;
      led       <= '0;
      irq_en    <= 1'b0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      timer_irq <= 1'b0;
      rdata_q   <= '0;
    end else begin
      scratch0  <= byte_merge(scratch0, bus.wdata, be_s0);
      scratch1  <= byte_merge(scratch1, bus.wdata, be_s1);
      led       <= led_wide[LED_W-1:0];
      irq_en    <= irq_en_nxt;
      sw_s1     <= sw;
      sw_s2     <= sw_s1;
      // irq tracks next-state so it rises with pending, not a cycle later
      timer_irq <= pending_nxt & irq_en_nxt;
      if (bus.en) begin
        rdata_q <= rd_val;
      end
    end
  end

  assign bus.rdata = rdata_q;

  assign unused_bits = ^{bus.addr[1:0], be_ist[3:1], be_ien[3:1],
                         led_wide[31:LED_W]};

endmodule

// File: tb/tb_mmio_sram_responder.sv
// Scoreboard bench for mmio_sram_responder: directed accesses queue
// expected rdata, a negedge monitor pops one entry per captured access.
module tb_mmio_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic en_q;

  mmio_sram_responder_if #(.ADDR_W(16)) bus ();

  mmio_sram_responder dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .sw        (sw),
    .led       (led),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) en_q <= 1'b0;
    else         en_q <= bus.en;
  end

  always @(negedge clk) begin
    if (en_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow got rdata %h expected none",
                 bus.rdata);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) chk(mon_e.nm, bus.rdata, mon_e.exp);
      end
    end
  end

  task automatic acc(input logic [3:0] w, input logic [15:0] a,
                     input logic [31:0] d, input bit c,
                     input logic [31:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    bus.en    = 1'b1;
    bus.wen   = w;
    bus.addr  = a;
    bus.wdata = d;
    x.chk = c;
    x.exp = e;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e,
                    input string nm);
    acc(4'b0000, a, 32'h0, 1'b1, e, nm);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.en  = 1'b0;
    bus.wen = 4'b0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    bus.en    = 1'b0;
    bus.wen   = 4'b0000;
    bus.addr  = '0;
    bus.wdata = '0;
    sw        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    rd(16'h0014, 32'hFFFF_FFFF, "rst_compare");
    rd(16'h0008, 32'h0000_0000, "rst_led_reg");
    rd(16'h0020, 32'h0000_0000, "miss_0x20");

    acc(4'b0001, 16'h0008, 32'h0000_A5A5, 1'b1, 32'h0, "led_wr_rf");
    rd(16'h0008, 32'h0000_00A5, "led_byte0");
    idle();
    chk("led_pin_a5", {16'h0, led}, 32'h0000_00A5);
    acc(4'b1111, 16'h0008, 32'hDEAD_BEEF, 1'b1, 32'h0000_00A5,
        "led_wr2_rf");
    rd(16'h0008, 32'h0000_BEEF, "led_trunc");
    idle();
    chk("led_pin_beef", {16'h0, led}, 32'h0000_BEEF);

    acc(4'b1111, 16'h0000, 32'h1234_5678, 1'b1, 32'h0, "s0_wr_rf");
    acc(4'b1100, 16'h0000, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678,
        "s0_raw");
    rd(16'h0000, 32'hFFFF_5678, "s0_partial");

    acc(4'b0001, 16'h001C, 32'h1, 1'b1, 32'h0, "ien_wr_rf");
    acc(4'b1111, 16'h0014, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF,
        "cmp_wr_rf");
    acc(4'b1111, 16'h0010, 32'hFFFF_FFFE, 1'b0, 32'h0, "tmr_wr");
    rd(16'h0010, 32'hFFFF_FFFE, "tmr_hold");
    rd(16'h0010, 32'hFFFF_FFFF, "tmr_max");
    rd(16'h0010, 32'h0000_0000, "tmr_wrap");
    rd(16'h0018, 32'h0000_0000, "pend_pre");
    rd(16'h0010, 32'h0000_0002, "tmr_two");
    rd(16'h0018, 32'h0000_0001, "pend_set");
    idle();
    chk("irq_high", {31'h0, timer_irq}, 32'h1);
    acc(4'b0001, 16'h0018, 32'h1, 1'b1, 32'h1, "w1c_rf");
    idle();
    chk("irq_clr", {31'h0, timer_irq}, 32'h0);

    acc(4'b1111, 16'h0014, 32'h0000_0100, 1'b1, 32'h0000_0001,
        "cmp2_rf");
    acc(4'b1111, 16'h0010, 32'h0000_00FE, 1'b0, 32'h0, "tmr2_wr");
    rd(16'h0010, 32'h0000_00FE, "tmr2_fe");
    rd(16'h0010, 32'h0000_00FF, "tmr2_ff");
    acc(4'b0001, 16'h0018, 32'h1, 1'b1, 32'h0, "w1c_match_rf");
    rd(16'h0018, 32'h0000_0001, "set_beats_clr");
    idle();
    chk("irq_stays", {31'h0, timer_irq}, 32'h1);

    rd(16'h000C, 32'h0000_0000, "sw_sync0");
    sw = 8'h3C;
    rd(16'h000C, 32'h0000_0000, "sw_sync1");
    rd(16'h000C, 32'h0000_003C, "sw_sync2");

    @(posedge clk);
    #1;
    bus.en    = 1'b1;
    bus.wen   = 4'b1111;
    bus.addr  = 16'h0000;
    bus.wdata = 32'hAAAA_5555;
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_rdata", bus.rdata, 32'h0);
    chk("midrst_led", {16'h0, led}, 32'h0);
    chk("midrst_irq", {31'h0, timer_irq}, 32'h0);
    bus.en  = 1'b0;
    bus.wen = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rd(16'h0000, 32'h0000_0000, "midrst_s0");
    rd(16'h0014, 32'hFFFF_FFFF, "midrst_cmp");
    rd(16'h001C, 32'h0000_0000, "midrst_ien");
    idle();
    idle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
